// File: rtl/hex_ascii_pkg.sv
// Shared definitions for the hex ASCII streamer: character codes, FSM states
// and the digit-counter width helper.
package hex_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_X       = 8'h78;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PFX0   = 3'd1,
    ST_PFX1   = 3'd2,
    ST_DIGIT  = 3'd3,
    ST_EOL_CR = 3'd4,
    ST_EOL_LF = 3'd5
  } state_t;

  // Counter must hold DATA_W/4-1; a single-digit word still needs one bit.
  function automatic int cnt_width(input int data_w);
    int w;
    w = $clog2(data_w / 32'sd4);
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/hex_ascii_streamer_nibble_to_ascii.sv
// Combinational map from one 4-bit nibble to its ASCII hex digit.
module nibble_to_ascii
  import hex_ascii_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       uppercase,
  output logic [7:0] ascii
);

  // Digits 0-9 start at '0'; 10-15 start at 'A' or 'a' depending on case.
  always_comb begin
    ascii = 8'h00;
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else if (uppercase) begin
      ascii = ASCII_UPPER_A + {4'h0, nibble} - 8'd10;
    end else begin
      ascii = ASCII_LOWER_A + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_ascii_streamer.sv
// Serialises one DATA_W-bit word into ASCII hex characters with optional
// "0x" prefix and CR/LF terminator, valid/ready on both sides.
module hex_ascii_streamer
  import hex_ascii_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter bit         PREFIX_EN = 1'b0,
  parameter logic [1:0] EOL_MODE  = 2'd0,
  parameter bit         UPPERCASE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W / 4 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if ((DATA_W % 4) != 0 || DATA_W < 4 || DATA_W > 32) begin : g_bad_data_w
    $error("hex_ascii_streamer: DATA_W must be a multiple of 4 in 4..32");
  end

  state_t              state_r;
  state_t              state_nxt_s;
  state_t              eol_state_s;
  logic [DATA_W-1:0]   shift_r;
  logic [DATA_W-1:0]   shift_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [7:0]          digit_s;
  logic [7:0]          out_data_nxt_s;
  logic                accept_s;
  logic                xfer_s;

  assign accept_s = in_valid & in_ready;
  assign xfer_s   = out_valid & out_ready;

  // Converter looks at the next-cycle MSBs so the digit register is ready
  // in the same cycle the shift register is loaded or shifted.
  nibble_to_ascii u_nibble_to_ascii (
    .nibble    (shift_nxt_s[DATA_W-1 -: 4]),
    .uppercase (UPPERCASE),
    .ascii     (digit_s)
  );

  // Where the FSM goes after the last digit.
  always_comb begin
    eol_state_s = ST_IDLE;
    if (EOL_MODE == 2'd2) begin
      eol_state_s = ST_EOL_CR;
    end else if (EOL_MODE == 2'd1) begin
      eol_state_s = ST_EOL_LF;
    end else begin
      eol_state_s = ST_IDLE;
    end
  end

  // Next-state, shift and counter logic; every non-IDLE move waits for a transfer.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          shift_nxt_s = in_data;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = PREFIX_EN ? ST_PFX0 : ST_DIGIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PFX0: begin
        if (xfer_s) begin
          state_nxt_s = ST_PFX1;
        end else begin
          state_nxt_s = ST_PFX0;
        end
      end
      ST_PFX1: begin
        if (xfer_s) begin
          state_nxt_s = ST_DIGIT;
        end else begin
          state_nxt_s = ST_PFX1;
        end
      end
      ST_DIGIT: begin
        if (xfer_s) begin
          shift_nxt_s = shift_r << 3'd4;
          if (cnt_r == '0) begin
            state_nxt_s = eol_state_s;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end else begin
          state_nxt_s = ST_DIGIT;
        end
      end
      ST_EOL_CR: begin
        if (xfer_s) begin
          state_nxt_s = ST_EOL_LF;
        end else begin
          state_nxt_s = ST_EOL_CR;
        end
      end
      ST_EOL_LF: begin
        if (xfer_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_EOL_LF;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Character presented in the state being entered.
  always_comb begin
    out_data_nxt_s = 8'h00;
    case (state_nxt_s)
      ST_PFX0:   out_data_nxt_s = ASCII_ZERO;
      ST_PFX1:   out_data_nxt_s = ASCII_X;
      ST_DIGIT:  out_data_nxt_s = digit_s;
      ST_EOL_CR: out_data_nxt_s = ASCII_CR;
      ST_EOL_LF: out_data_nxt_s = ASCII_LF;
      default:   out_data_nxt_s = 8'h00;
    endcase
  end

  // State and all outputs registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      cnt_r     <= cnt_nxt_s;
      out_valid <= (state_nxt_s != ST_IDLE);
      out_data  <= out_data_nxt_s;
      in_ready  <= (state_nxt_s == ST_IDLE);
      busy      <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Directed self-checking bench: three streamer configurations sharing one clock.
module tb_hex_ascii_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // A: defaults (8-bit, no prefix, no EOL, uppercase)
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0] a_in_data, a_out_data;
  // B: 16-bit, prefix, CR LF
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [15:0] b_in_data;
  logic [7:0]  b_out_data;
  // C: 8-bit lowercase
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [7:0] c_in_data, c_out_data;

  hex_ascii_streamer u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(a_out_ready), .busy(a_busy)
  );

  hex_ascii_streamer #(.DATA_W(16), .PREFIX_EN(1'b1), .EOL_MODE(2'd2), .UPPERCASE(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .busy(b_busy)
  );

  hex_ascii_streamer #(.DATA_W(8), .PREFIX_EN(1'b0), .EOL_MODE(2'd0), .UPPERCASE(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_ready(c_out_ready), .busy(c_busy)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({a_out_valid, a_out_data, a_in_ready, a_busy} !== {1'b0, 8'h00, 1'b1, 1'b0})
      $display("FAIL reset_a: v/d/rdy/busy=%b/%h/%b/%b expected 0/00/1/0", a_out_valid, a_out_data, a_in_ready, a_busy);
    else pass_cnt++;
    total_cnt++;
    if ({b_out_valid, b_out_data, b_in_ready, b_busy} !== {1'b0, 8'h00, 1'b1, 1'b0})
      $display("FAIL reset_b: v/d/rdy/busy=%b/%h/%b/%b expected 0/00/1/0", b_out_valid, b_out_data, b_in_ready, b_busy);
    else pass_cnt++;
    total_cnt++;
    if ({c_out_valid, c_out_data, c_in_ready, c_busy} !== {1'b0, 8'h00, 1'b1, 1'b0})
      $display("FAIL reset_c: v/d/rdy/busy=%b/%h/%b/%b expected 0/00/1/0", c_out_valid, c_out_data, c_in_ready, c_busy);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_chars [2] = '{8'h33, 8'h43};
    a_out_ready = 1'b1;
    a_in_data   = 8'h3C;
    a_in_valid  = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if ({a_out_valid, a_out_data, a_in_ready} !== {1'b1, exp_chars[i], 1'b0})
        $display("FAIL basic_char%0d: v/d/rdy=%b/%h/%b expected 1/%h/0", i, a_out_valid, a_out_data, a_in_ready, exp_chars[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({a_out_valid, a_in_ready, a_busy} !== {1'b0, 1'b1, 1'b0})
      $display("FAIL basic_end: v/rdy/busy=%b/%b/%b expected 0/1/0", a_out_valid, a_in_ready, a_busy);
    else pass_cnt++;
  endtask

  task automatic test_prefix_eol();
    logic [7:0] exp_chars [8] = '{8'h30, 8'h78, 8'h41, 8'h30, 8'h35, 8'h46, 8'h0D, 8'h0A};
    int busy_cycles = 0;
    b_out_ready = 1'b1;
    b_in_data   = 16'hA05F;
    b_in_valid  = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if ({b_out_valid, b_out_data} !== {1'b1, exp_chars[i]})
        $display("FAIL pfx_eol_char%0d: v/d=%b/%h expected 1/%h", i, b_out_valid, b_out_data, exp_chars[i]);
      else pass_cnt++;
      if (b_busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    if (b_busy === 1'b1) busy_cycles++;
    total_cnt++;
    if (busy_cycles != 8 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1)
      $display("FAIL pfx_eol_busy: busy_cycles=%0d v=%b rdy=%b expected 8/0/1", busy_cycles, b_out_valid, b_in_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_data   = 8'h7E;
    a_in_valid  = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({a_out_valid, a_out_data} !== {1'b1, 8'h37})
        $display("FAIL bp_hold%0d: v/d=%b/%h expected 1/37", i, a_out_valid, a_out_data);
      else pass_cnt++;
      if (i < 2) @(negedge clk);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({a_out_valid, a_out_data} !== {1'b1, 8'h45})
      $display("FAIL bp_second: v/d=%b/%h expected 1/45", a_out_valid, a_out_data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({a_out_valid, a_in_ready} !== {1'b0, 1'b1})
      $display("FAIL bp_end: v/rdy=%b/%b expected 0/1", a_out_valid, a_in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_chars [2] = '{8'h31, 8'h32};
    a_out_ready = 1'b1;
    a_in_data   = 8'h12;
    a_in_valid  = 1'b1;
    @(negedge clk);
    a_in_data = 8'h99;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if ({a_out_valid, a_out_data, a_in_ready} !== {1'b1, exp_chars[i], 1'b0})
        $display("FAIL b2b_first%0d: v/d/rdy=%b/%h/%b expected 1/%h/0", i, a_out_valid, a_out_data, a_in_ready, exp_chars[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({a_out_valid, a_in_ready} !== {1'b0, 1'b1})
      $display("FAIL b2b_gap: v/rdy=%b/%b expected 0/1", a_out_valid, a_in_ready);
    else pass_cnt++;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if ({a_out_valid, a_out_data} !== {1'b1, 8'h39})
        $display("FAIL b2b_second%0d: v/d=%b/%h expected 1/39", i, a_out_valid, a_out_data);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({a_out_valid, a_in_ready} !== {1'b0, 1'b1})
      $display("FAIL b2b_end: v/rdy=%b/%b expected 0/1", a_out_valid, a_in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    a_out_ready = 1'b1;
    a_in_data   = 8'hAB;
    a_in_valid  = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    total_cnt++;
    if ({a_out_valid, a_out_data} !== {1'b1, 8'h41})
      $display("FAIL rstmid_first: v/d=%b/%h expected 1/41", a_out_valid, a_out_data);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({a_out_valid, a_out_data, a_in_ready, a_busy} !== {1'b0, 8'h00, 1'b1, 1'b0})
      $display("FAIL rstmid_after: v/d/rdy/busy=%b/%h/%b/%b expected 0/00/1/0", a_out_valid, a_out_data, a_in_ready, a_busy);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_out_valid !== 1'b0) stray++;
    end
    total_cnt++;
    if (stray != 0)
      $display("FAIL rstmid_no_more: stray_chars=%0d expected 0", stray);
    else pass_cnt++;
  endtask

  task automatic test_lowercase();
    logic [7:0] words [2] = '{8'hFF, 8'h00};
    logic [7:0] exp_chars [2] = '{8'h66, 8'h30};
    c_out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      c_in_data  = words[w];
      c_in_valid = 1'b1;
      @(negedge clk);
      c_in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if ({c_out_valid, c_out_data} !== {1'b1, exp_chars[w]})
          $display("FAIL lower_w%0d_c%0d: v/d=%b/%h expected 1/%h", w, i, c_out_valid, c_out_data, exp_chars[w]);
        else pass_cnt++;
        @(negedge clk);
      end
      total_cnt++;
      if ({c_out_valid, c_in_ready} !== {1'b0, 1'b1})
        $display("FAIL lower_end%0d: v/rdy=%b/%b expected 0/1", w, c_out_valid, c_in_ready);
      else pass_cnt++;
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 16'h0000; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_prefix_eol();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_lowercase();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hex_ascii_streamer.md
# hex_ascii_streamer

Parametrised binary-to-ASCII-hex serializer between the ALU result path and the UART transmitter. Accepts one DATA_W-bit word per transaction and emits it as a stream of 8-bit ASCII characters, most-significant nibble first. Each string has an optional "0x" prefix and an optional CR/LF terminator. It replaces the fixed 8-bit, two-character encoder with a valid/ready interface on both sides, back-pressure support and no silent overwrite of in-flight data.

## Interface
- DATA_W, 8: input word width; a multiple of 4, range 4..32.
- PREFIX_EN, 0: 1 = emit "0x" (0x30, 0x78) before the digits.
- EOL_MODE, 0: 0 = no terminator; 1 = LF (0x0A); 2 = CR LF (0x0D, 0x0A).
- UPPERCASE, 1: 1 = digits A-F are 0x41-0x46; 0 = digits a-f are 0x61-0x66.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_data  in  DATA_W  word to encode.
- in_ready  out  1  block idle and able to accept a word.
- out_valid  out  1  out_data holds a character.
- out_data  out  8  ASCII character.
- out_ready  in  1  UART transmitter accepts the character.
- busy  out  1  a string is in progress (not IDLE).

## Operation
- Input transfer: in_valid & in_ready at a rising edge. in_data is latched into the shift register and the digit counter is loaded with DATA_W/4-1.
- Output transfer: out_valid & out_ready at a rising edge.
- States: IDLE, PFX0, PFX1, DIGIT, EOL_CR, EOL_LF.
  - IDLE → PFX0 if PREFIX_EN, else → DIGIT.
  - PFX0 → PFX1 → DIGIT.
  - DIGIT stays in DIGIT until the counter reaches 0, then → EOL_CR (EOL_MODE=2), EOL_LF (EOL_MODE=1) or IDLE (EOL_MODE=0).
  - EOL_CR → EOL_LF → IDLE.
  - Every non-IDLE transition happens only on an output transfer.
- DIGIT: out_data = ASCII of shift-register bits [DATA_W-1:DATA_W-4]. On transfer, shift left by 4 and decrement the counter.
- Characters per word: 2·PREFIX_EN + DATA_W/4 + EOL_MODE.
- Outputs are registered. out_data and out_valid change only after an output transfer, an input transfer or reset.
- in_ready = (state == IDLE); it is registered, with no combinational path from out_ready.
- busy = !in_ready.
- Reset values: state IDLE, out_valid 0, out_data 0x00, in_ready 1, busy 0, shift register 0, counter 0.

## Timing
- Latency: input transfer at edge N; first character valid after edge N (out_valid high in cycle N+1).
- Throughput: with out_ready held high, one character per cycle and out_valid continuously high for the whole string.
- The cycle after the last output transfer, out_valid = 0 and in_ready = 1. The minimum gap between strings is one idle cycle.
- Back-pressure: while out_valid & !out_ready, out_data and state hold indefinitely. No character is lost or duplicated.
- in_valid during busy: ignored, in_ready stays 0, in_data is not sampled. No overwrite of the active string.
- out_ready high while out_valid low: no effect.
- Reset mid-string: at the next edge all registers take their reset values. The partial string is dropped with no further characters.
- rst has priority over simultaneous in_valid and out_ready.

## Structure
- Shared package hex_ascii_pkg holds:
  - the ASCII constants (0x30, 0x78, 0x0D, 0x0A, 0x41, 0x61);
  - the state enum (IDLE..EOL_LF);
  - a digit-counter width function, clog2(DATA_W/4), minimum 1.
- One sub-module: nibble_to_ascii. It is combinational, maps 4 bits plus UPPERCASE to 8 bits, and is instantiated once on the shift-register MSBs.
- Top level holds the FSM, shift register, counter and output registers.
- Elaboration-time check rejects a DATA_W that is not a multiple of 4 or is outside 4..32.

## Test plan
- Defaults, in_data 0x3C, out_ready=1 → out_data 0x33 then 0x43 in consecutive cycles starting the cycle after acceptance; then out_valid 0, in_ready 1.
- DATA_W=16, PREFIX_EN=1, EOL_MODE=2, in_data 0xA05F → 0x30, 0x78, 0x41, 0x30, 0x35, 0x46, 0x0D, 0x0A; busy high for exactly 8 cycles.
- Back-pressure: DATA_W=8, in_data 0x7E, out_ready low for 3 cycles after the first character appears → out_data holds 0x37 stable; then 0x37, 0x45 each transferred exactly once.
- in_valid with in_data 0x99 asserted mid-string with 0x12 → in_ready 0, output stays 0x31, 0x32; 0x99 accepted only after IDLE, giving 0x39, 0x39.
- rst pulsed after the first character of 0xAB (DATA_W=8) → next cycle out_valid 0, out_data 0x00, in_ready 1; no 0x42 emitted.
- UPPERCASE=0, in_data 0xFF → 0x66, 0x66; in_data 0x00 → 0x30, 0x30.
